// File: rtl/moldudp64_pkg.sv
// moldudp64_pkg: shared widths, end-of-session marker, FSM and classification types
package moldudp64_pkg;
   localparam int SEQ_W = 64;
   localparam int ML_W = 16;
   localparam logic [15:0] MSG_CNT_EOS = 16'hFFFF;
   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;
   typedef enum logic [1:0] {CLS_FWD, CLS_DUP, CLS_HB, CLS_EOS} cls_e;
endpackage

// File: rtl/moldudp64_seq_cls.sv
// moldudp64_seq_cls: classifies a header against the next expected sequence number
module moldudp64_seq_cls #(
   parameter int SEQ_W = 64,
   parameter int ML_W = 16
) (
   input  logic [SEQ_W-1:0]        exp_i,
   input  logic                    sync_i,
   input  logic [SEQ_W-1:0]        seq_i,
   input  logic [ML_W-1:0]         cnt_i,
   output moldudp64_pkg::cls_e     cls_o,
   output logic [ML_W-1:0]         skip_o,
   output logic                    gap_v_o,
   output logic [SEQ_W-1:0]        gap_seq_o,
   output logic [SEQ_W-1:0]        gap_len_o,
   output logic [SEQ_W-1:0]        exp_next_o
);
   import moldudp64_pkg::*;
   logic [SEQ_W-1:0] end_w;
   always_comb begin
      end_w = seq_i + SEQ_W'(cnt_i);
      cls_o = CLS_FWD;
      skip_o = '0;
      gap_v_o = 1'b0;
      gap_seq_o = exp_i;
      gap_len_o = seq_i - exp_i;
      exp_next_o = end_w;
      if (cnt_i == ML_W'(MSG_CNT_EOS)) begin
         cls_o = CLS_EOS;
         exp_next_o = exp_i;
      end else if (!sync_i) begin
         cls_o = (cnt_i != '0) ? CLS_FWD : CLS_HB;
      end else if (cnt_i == '0) begin
         cls_o = CLS_HB;
         gap_v_o = seq_i > exp_i;
         exp_next_o = gap_v_o ? seq_i : exp_i;
      end else if (end_w <= exp_i) begin
         cls_o = CLS_DUP;
         exp_next_o = exp_i;
      end else if (seq_i <= exp_i) begin
         skip_o = ML_W'(exp_i - seq_i);
      end else begin
         gap_v_o = 1'b1;
      end
   end
endmodule

// File: rtl/moldudp64_ab_arbiter.sv
// moldudp64_ab_arbiter: A/B feed arbiter forwarding the first useful copy of each packet
module moldudp64_ab_arbiter #(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = 8,
   parameter int SEQ_W = 64,
   parameter int ML_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_hdr_v_i,
   input  logic [SEQ_W-1:0]      a_seq_num_i,
   input  logic [ML_W-1:0]       a_msg_cnt_i,
   input  logic                  a_axis_tvalid_i,
   input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
   input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
   input  logic                  a_axis_tlast_i,
   output logic                  a_axis_tready_o,
   input  logic                  b_hdr_v_i,
   input  logic [SEQ_W-1:0]      b_seq_num_i,
   input  logic [ML_W-1:0]       b_msg_cnt_i,
   input  logic                  b_axis_tvalid_i,
   input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
   input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
   input  logic                  b_axis_tlast_i,
   output logic                  b_axis_tready_o,
   output logic                  m_axis_tvalid_o,
   output logic [AXI_KEEP_W-1:0] m_axis_tkeep_o,
   output logic [AXI_DATA_W-1:0] m_axis_tdata_o,
   output logic                  m_axis_tlast_o,
   input  logic                  m_axis_tready_i,
   output logic                  m_sop_o,
   output logic [SEQ_W-1:0]      m_seq_num_o,
   output logic [ML_W-1:0]       m_msg_cnt_o,
   output logic [ML_W-1:0]       m_skip_o,
   output logic                  gap_v_o,
   output logic [SEQ_W-1:0]      gap_seq_o,
   output logic [SEQ_W-1:0]      gap_len_o,
   output logic                  eos_v_o
);
   import moldudp64_pkg::*;
   state_e state_q, state_d;
   cls_e cls;
   logic sel_q, sel_d, last_q, last_d, sync_q, sync_d, sop_q, sop_d;
   logic gap_v_q, gap_v_d, eos_v_q, eos_v_d;
   logic [SEQ_W-1:0] exp_q, exp_d, seq_q, seq_d, gap_seq_q, gap_seq_d, gap_len_q, gap_len_d;
   logic [ML_W-1:0] cnt_q, cnt_d, skip_q, skip_d;
   logic pick_b, s_valid, s_last, s_ready, hs, c_gap_v;
   logic [SEQ_W-1:0] c_seq, c_gap_seq, c_gap_len, c_exp;
   logic [ML_W-1:0] c_cnt, c_skip;
   // last_q high means B was granted last; ties go to the other feed
   assign pick_b = b_hdr_v_i & (!a_hdr_v_i | (b_seq_num_i < a_seq_num_i) |
                                ((b_seq_num_i == a_seq_num_i) & !last_q));
   assign c_seq = pick_b ? b_seq_num_i : a_seq_num_i;
   assign c_cnt = pick_b ? b_msg_cnt_i : a_msg_cnt_i;
   moldudp64_seq_cls #(.SEQ_W(SEQ_W), .ML_W(ML_W)) u_cls (
      .exp_i(exp_q), .sync_i(sync_q), .seq_i(c_seq), .cnt_i(c_cnt),
      .cls_o(cls), .skip_o(c_skip), .gap_v_o(c_gap_v), .gap_seq_o(c_gap_seq),
      .gap_len_o(c_gap_len), .exp_next_o(c_exp)
   );
   assign s_valid = sel_q ? b_axis_tvalid_i : a_axis_tvalid_i;
   assign s_last = sel_q ? b_axis_tlast_i : a_axis_tlast_i;
   assign s_ready = (state_q == ST_FWD) ? m_axis_tready_i : (state_q == ST_DROP);
   assign hs = s_valid & s_ready;
   assign a_axis_tready_o = !sel_q & s_ready;
   assign b_axis_tready_o = sel_q & s_ready;
   assign m_axis_tvalid_o = (state_q == ST_FWD) & s_valid;
   assign m_axis_tkeep_o = sel_q ? b_axis_tkeep_i : a_axis_tkeep_i;
   assign m_axis_tdata_o = sel_q ? b_axis_tdata_i : a_axis_tdata_i;
   assign m_axis_tlast_o = s_last;
   assign m_sop_o = sop_q & (state_q == ST_FWD);
   assign m_seq_num_o = seq_q;
   assign m_msg_cnt_o = cnt_q;
   assign m_skip_o = skip_q;
   assign gap_v_o = gap_v_q;
   assign gap_seq_o = gap_seq_q;
   assign gap_len_o = gap_len_q;
   assign eos_v_o = eos_v_q;
   always_comb begin
      state_d = state_q;
      sel_d = sel_q;
      last_d = last_q;
      sync_d = sync_q;
      sop_d = sop_q;
      exp_d = exp_q;
      seq_d = seq_q;
      cnt_d = cnt_q;
      skip_d = skip_q;
      gap_seq_d = gap_seq_q;
      gap_len_d = gap_len_q;
      gap_v_d = 1'b0;
      eos_v_d = 1'b0;
      if (state_q == ST_IDLE) begin
         if (a_hdr_v_i | b_hdr_v_i) begin
            state_d = (cls == CLS_FWD) ? ST_FWD : ST_DROP;
            sel_d = pick_b;
            sync_d = sync_q | (cls != CLS_EOS);
            sop_d = 1'b1;
            exp_d = c_exp;
            seq_d = c_seq;
            cnt_d = c_cnt;
            skip_d = c_skip;
            gap_v_d = c_gap_v;
            gap_seq_d = c_gap_seq;
            gap_len_d = c_gap_len;
            eos_v_d = cls == CLS_EOS;
         end
      end else if (hs) begin
         sop_d = 1'b0;
         state_d = s_last ? ST_IDLE : state_q;
         last_d = s_last ? sel_q : last_q;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q <= 1'b0;
         last_q <= 1'b1;
         sync_q <= 1'b0;
         sop_q <= 1'b0;
         exp_q <= '0;
         seq_q <= '0;
         cnt_q <= '0;
         skip_q <= '0;
         gap_v_q <= 1'b0;
         gap_seq_q <= '0;
         gap_len_q <= '0;
         eos_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q <= sel_d;
         last_q <= last_d;
         sync_q <= sync_d;
         sop_q <= sop_d;
         exp_q <= exp_d;
         seq_q <= seq_d;
         cnt_q <= cnt_d;
         skip_q <= skip_d;
         gap_v_q <= gap_v_d;
         gap_seq_q <= gap_seq_d;
         gap_len_q <= gap_len_d;
         eos_v_q <= eos_v_d;
      end
   end
endmodule
